// File: rtl/dma_ctrl_pkg.sv
// dma_ctrl_pkg: shared state encoding and default descriptor for dma_bus_ctrl
package dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BR,
        DRAIN,
        GRANT,
        DONE
    } state_t;

    localparam logic [15:0] DEF_DMA_TARGET = 16'h000B;
    localparam logic [15:0] DEF_DMA_LENGTH = 16'd12;

endpackage

// File: rtl/dma_watchdog.sv
// dma_watchdog: grant-duration counter with clear, enable and expire
module dma_watchdog #(
    parameter int unsigned WD_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;

    logic [CW-1:0] count;

    // count grant cycles; restarts from zero each time a grant begins
    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expire = enable && (count == CW'(WD_CYCLES - 1));

endmodule

// File: rtl/dma_bus_ctrl.sv
// dma_bus_ctrl: CPU/DMA bus arbitration and fixed-descriptor DMA launch
// Optional feature: DMA_WATCHDOG_EN aborts a grant that outlasts WD_CYCLES.
module dma_bus_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned          WORD_SIZE  = 16,
    parameter logic [WORD_SIZE-1:0] DMA_TARGET = WORD_SIZE'(DEF_DMA_TARGET),
    parameter logic [WORD_SIZE-1:0] DMA_LENGTH = WORD_SIZE'(DEF_DMA_LENGTH),
    parameter int unsigned          WD_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ext_irq,
    input  logic                 cpu_mem_busy,
    input  logic                 br,
    input  logic                 dma_end,
    output logic                 bg,
    output logic                 begin_dma,
    output logic [WORD_SIZE-1:0] target_address,
    output logic [WORD_SIZE-1:0] length,
    output logic                 cpu_bus_hold,
    output logic                 dma_done_irq,
    output logic                 dma_abort
);

    state_t state, nxt;
    logic   ext_irq_q;
    logic   pending;
    logic   irq_edge;
    logic   expire;

    assign irq_edge = ext_irq & ~ext_irq_q;

`ifdef DMA_WATCHDOG_EN
    dma_watchdog #(
        .WD_CYCLES(WD_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != GRANT && nxt == GRANT),
        .enable (state == GRANT),
        .expire (expire)
    );
`else
    logic unused_wd;
    assign unused_wd = (WD_CYCLES != 0);
    assign expire    = 1'b0;
    assign dma_abort = 1'b0;
`endif

    // next-state decode; dma_end only matters while the bus is granted
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (irq_edge || pending) ? START : IDLE;
            START:   nxt = WAIT_BR;
            WAIT_BR: nxt = !br ? WAIT_BR : (cpu_mem_busy ? DRAIN : GRANT);
            DRAIN:   nxt = cpu_mem_busy ? DRAIN : GRANT;
            GRANT:   nxt = (dma_end || expire) ? DONE : GRANT;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, pending request, descriptor and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            ext_irq_q      <= 1'b0;
            pending        <= 1'b0;
            begin_dma      <= 1'b0;
            bg             <= 1'b0;
            cpu_bus_hold   <= 1'b0;
            dma_done_irq   <= 1'b0;
            target_address <= '0;
            length         <= '0;
`ifdef DMA_WATCHDOG_EN
            dma_abort      <= 1'b0;
`endif
        end else begin
            state        <= nxt;
            ext_irq_q    <= ext_irq;
            pending      <= (state == IDLE) ? 1'b0 : (pending | irq_edge);
            begin_dma    <= (nxt == START);
            bg           <= (nxt == GRANT);
            cpu_bus_hold <= (nxt == GRANT) || (nxt == DRAIN);
            dma_done_irq <= (state == GRANT) && dma_end;
`ifdef DMA_WATCHDOG_EN
            dma_abort    <= (state == GRANT) && !dma_end && expire;
`endif
            if (nxt == START) begin
                target_address <= DMA_TARGET;
                length         <= DMA_LENGTH;
            end
        end
    end

endmodule

// File: doc/dma_bus_ctrl.md
# dma_bus_ctrl

Controls the shared memory bus between the CPU cache and the external DMA engine. It detects external-device interrupts and launches a DMA transfer with a fixed descriptor. It grants the bus only once the cache has no memory transaction in flight, and signals completion back to the CPU. It sits beside the cache in `cpu` and owns the `br`/`bg`/`begin_dma`/`dma_end` handshake, which it removes from the top level.

## Interface
Parameters:
- WORD_SIZE, 16, address/length width
- DMA_TARGET, 16'h000B, target address issued with every transfer
- DMA_LENGTH, 12, word count issued with every transfer
- WD_CYCLES, 64, watchdog limit in cycles (used only with DMA_WATCHDOG_EN)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset_n  in  1  reset; synchronous, active-low
- ext_irq  in  1  level interrupt from external device; a transfer request is its rising edge
- cpu_mem_busy  in  1  cache has a miss fill or writeback in flight
- br  in  1  DMA bus request
- dma_end  in  1  DMA transfer finished
- bg  out  1  bus grant to DMA
- begin_dma  out  1  one-cycle start pulse to DMA
- target_address  out  WORD_SIZE  descriptor address, valid from begin_dma until the next start
- length  out  WORD_SIZE  descriptor word count, same validity
- cpu_bus_hold  out  1  cache must not start a new memory access
- dma_done_irq  out  1  one-cycle completion pulse to CPU
- dma_abort  out  1  one-cycle watchdog abort pulse; constant 0 without DMA_WATCHDOG_EN

## Operation
- Edge detect: register ext_irq_q; an edge is ext_irq & ~ext_irq_q.
- States:
  - IDLE
  - START: begin_dma=1
  - WAIT_BR
  - DRAIN: cpu_bus_hold=1
  - GRANT: bg=1, cpu_bus_hold=1
  - DONE: dma_done_irq=1 or dma_abort=1
- IDLE -> START on an edge or when the pending flag is set. Leaving IDLE clears the pending flag.
- START -> WAIT_BR unconditionally. On entry to START, latch target_address=DMA_TARGET and length=DMA_LENGTH.
- WAIT_BR:
  - br & ~cpu_mem_busy -> GRANT
  - br & cpu_mem_busy -> DRAIN
  - otherwise stay
- DRAIN -> GRANT when cpu_mem_busy=0.
- GRANT -> DONE on dma_end. Deassertion of br in GRANT is ignored; bg holds until dma_end.
- DONE -> IDLE unconditionally. When pending is set, the next cycle goes IDLE -> START.
- An edge seen in any state other than IDLE sets a one-deep pending flag. Further edges while pending is set are dropped.
- dma_end outside GRANT is ignored.
- All outputs are decoded from registered state and latched descriptor registers; there is no combinational input-to-output path.

## Timing
- Reset (reset_n sampled low at a posedge): state=IDLE, pending=0, ext_irq_q=0, and every output is 0, including target_address and length. Reset mid-transfer drops bg on the next cycle with no dma_done_irq.
- Edge sampled at posedge N: begin_dma is high for exactly the cycle after N.
- br sampled high at posedge M with cpu_mem_busy=0: bg is high from the cycle after M, giving a minimum latency of 1 cycle.
- With cpu_mem_busy=1, bg rises the cycle after the first posedge at which cpu_mem_busy is sampled 0.
- cpu_bus_hold is high whenever bg is high and during DRAIN.
- dma_end sampled at posedge P: bg=0 and dma_done_irq=1 in the cycle after P, lasting 1 cycle.
- Back-to-back transfers: the minimum gap from dma_done_irq to the next begin_dma is 1 cycle.

## Configuration
- DMA_WATCHDOG_EN defined:
  - A counter clears on entry to GRANT and increments each cycle in GRANT.
  - If the count reaches WD_CYCLES-1 without dma_end, the controller goes to DONE and pulses dma_abort instead of dma_done_irq.
  - dma_end on the same edge as the limit wins, giving a normal completion.
- DMA_WATCHDOG_EN undefined: no counter, dma_abort tied 0, and GRANT waits for dma_end indefinitely.

## Structure
- Shared package dma_ctrl_pkg:
  - state enum (IDLE, START, WAIT_BR, DRAIN, GRANT, DONE)
  - default DMA_TARGET and DMA_LENGTH constants
- One natural sub-module: dma_watchdog, the counter with clear, enable and expire outputs. It is instantiated only under DMA_WATCHDOG_EN.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with ext_irq=1 -> all outputs 0. Release with ext_irq still 1 -> begin_dma pulses once, because the level rises after ext_irq_q clears.
- Basic transfer: ext_irq 0->1 -> begin_dma 1 cycle with target_address=0x000B and length=12. br=1 with cpu_mem_busy=0 -> bg next cycle. dma_end -> bg=0 and a 1-cycle dma_done_irq.
- Drain: br=1 while cpu_mem_busy=1 for 5 cycles -> cpu_bus_hold=1 and bg=0 for those cycles. bg rises 1 cycle after busy drops.
- Pending: second ext_irq edge during GRANT -> one extra begin_dma 2 cycles after dma_done_irq. A third edge during the same GRANT -> no additional transfer.
- Reset mid-GRANT: reset_n=0 for 1 cycle -> bg=0, no dma_done_irq, state IDLE.
- Watchdog (DMA_WATCHDOG_EN, WD_CYCLES=8): grant with no dma_end -> dma_abort pulse and bg=0 exactly 8 cycles after bg rose.
